// File: rtl/reg_file_mp_if.sv
// Bus interface for reg_file_mp: read ports, two write slots, issue marking and
// the write-collision flag. Scalar clk/reset stay plain ports on the module.
interface reg_file_mp_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NUM_RD = 4
);
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     we0;
    logic                     we1;
    logic [ADDR_W-1:0]        wa0;
    logic [ADDR_W-1:0]        wa1;
    logic [DATA_W-1:0]        wd0;
    logic [DATA_W-1:0]        wd1;
    logic                     iss_valid;
    logic [ADDR_W-1:0]        iss_addr;
    logic                     wr_collide;

    modport master (
        output rd_addr, we0, we1, wa0, wa1, wd0, wd1, iss_valid, iss_addr,
        input  rd_data, rd_busy, wr_collide
    );

    modport slave (
        input  rd_addr, we0, we1, wa0, wa1, wd0, wd1, iss_valid, iss_addr,
        output rd_data, rd_busy, wr_collide
    );
endinterface

// File: rtl/reg_file_mp.sv
// Multi-port register file with pending-write scoreboard; register 0 reads zero.
// Optional same-cycle write-to-read bypass enabled by defining REGFILE_BYPASS_EN.
module reg_file_mp #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NUM_RD = 4
) (
    input  logic           clk,
    input  logic           reset,
    reg_file_mp_if.slave   rf
);
    localparam int unsigned NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [NREGS];
    logic [NREGS-1:0]  busy;
    logic [NREGS-1:0]  busy_nxt;
    logic              collide_nxt;

    // Clears first, then the issue set, so a same-cycle re-issue keeps the bit.
    always_comb begin
        busy_nxt = busy;
        if (rf.we0) busy_nxt[rf.wa0] = 1'b0;
        if (rf.we1) busy_nxt[rf.wa1] = 1'b0;
        if (rf.iss_valid) busy_nxt[rf.iss_addr] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    assign collide_nxt = rf.we0 && rf.we1 && (rf.wa0 == rf.wa1) && (rf.wa0 != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                mem[ADDR_W'(i)] <= '0;
            end
            busy          <= '0;
            rf.wr_collide <= 1'b0;
        end else begin
            if (rf.we0 && (rf.wa0 != '0)) mem[rf.wa0] <= rf.wd0;
            // Slot 1 is the younger write; its later assignment wins on a tie.
            if (rf.we1 && (rf.wa1 != '0)) mem[rf.wa1] <= rf.wd1;
            busy          <= busy_nxt;
            rf.wr_collide <= collide_nxt;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic              b;

        assign a = rf.rd_addr[k*ADDR_W +: ADDR_W];

        always_comb begin
            d = '0;
            b = 1'b0;
            if (a != '0) begin
                d = mem[a];
                b = busy[a];
`ifdef REGFILE_BYPASS_EN
                if ((rf.we1 && (rf.wa1 == a)) || (rf.we0 && (rf.wa0 == a))) begin
                    d = (rf.we1 && (rf.wa1 == a)) ? rf.wd1 : rf.wd0;
                    // The write retires the producer unless a new issue re-targets it now.
                    b = (rf.iss_valid && (rf.iss_addr == a)) ? busy[a] : 1'b0;
                end
`endif
            end
        end

        assign rf.rd_data[k*DATA_W +: DATA_W] = d;
        assign rf.rd_busy[k]                  = b;
    end
endmodule
